// File: rtl/zap_fetch_sequencer_pkg.sv
// zap_fetch_sequencer_pkg: shared state encoding, fetch strides and skid entry layout
package zap_fetch_sequencer_pkg;
  typedef enum logic [1:0] {RUN, HOLD, HALT} fetch_state_e;
  localparam logic [31:0] ARM_STRIDE   = 32'd4;
  localparam logic [31:0] THUMB_STRIDE = 32'd2;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        abort;
  } fetch_entry_t;
endpackage

// File: rtl/zap_fetch_skid.sv
// zap_fetch_skid: one-entry buffer holding a cache response that arrived during a stall
module zap_fetch_skid
  import zap_fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         flush,
  input  fetch_entry_t d,
  output fetch_entry_t q,
  output logic         full
);
  logic         full_q, full_d;
  fetch_entry_t entry_q, entry_d;
  always_comb begin
    full_d  = flush ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : full_q;
    entry_d = (load && !flush) ? d : entry_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end
  assign q    = entry_q;
  assign full = full_q;
endmodule

// File: rtl/zap_fetch_sequencer.sv
// zap_fetch_sequencer: fetch PC generation, redirect priority and single-outstanding I-cache requests
module zap_fetch_sequencer
  import zap_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_code_stall,
  input  logic        i_clear_from_writeback,
  input  logic [31:0] i_pc_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic [31:0] i_pc_from_alu,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_pc_from_decode,
  input  logic        i_cpsr_ff_t,
  output logic        o_icache_req,
  output logic [31:0] o_icache_addr,
  input  logic        i_icache_ack,
  input  logic [31:0] i_icache_data,
  input  logic        i_icache_abort,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort
);
  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d, addr_q, addr_d, pc_ff_q, pc_ff_d, instr_q, instr_d;
  logic         req_q, req_d, kill_q, kill_d, valid_q, valid_d, abort_q, abort_d;
  logic         clear, ack, take, skid_unload, skid_full;
  logic [31:0]  clear_pc, next_pc;
  fetch_entry_t skid_q;
  assign clear    = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
  assign clear_pc = i_clear_from_writeback ? i_pc_from_writeback :
                    i_clear_from_alu       ? i_pc_from_alu       : i_pc_from_decode;
  // req_q doubles as the request-pending flag, so stray acks are ignored
  assign ack         = i_icache_ack & req_q;
  assign take        = ack & ~kill_q & ~clear & (state_q == RUN);
  assign next_pc     = fetch_pc_q + (i_cpsr_ff_t ? THUMB_STRIDE : ARM_STRIDE);
  assign skid_unload = ~clear & (state_q == HOLD) & skid_full & ~i_code_stall;
  zap_fetch_skid u_skid (
    .clk    (i_clk),
    .rst    (i_reset),
    .load   (take & i_code_stall),
    .unload (skid_unload),
    .flush  (clear),
    .d      ('{data: i_icache_data, pc: fetch_pc_q, abort: i_icache_abort}),
    .q      (skid_q),
    .full   (skid_full)
  );
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    abort_d    = abort_q;
    pc_ff_d    = pc_ff_q;
    instr_d    = instr_q;
    if (clear) begin
      state_d    = RUN;
      fetch_pc_d = clear_pc;
      req_d      = 1'b1;
      addr_d     = clear_pc & ~32'd3;
      kill_d     = req_q & ~i_icache_ack;
      valid_d    = 1'b0;
      abort_d    = 1'b0;
    end else begin
      if (ack && kill_q) kill_d = 1'b0;
      if (take) begin
        fetch_pc_d = next_pc;
        addr_d     = next_pc & ~32'd3;
        req_d      = ~i_code_stall & ~i_icache_abort;
        state_d    = i_code_stall ? HOLD : i_icache_abort ? HALT : RUN;
      end
      if (take && !i_code_stall) begin
        valid_d = 1'b1;
        abort_d = i_icache_abort;
        pc_ff_d = fetch_pc_q;
        instr_d = i_icache_data;
      end else if (skid_unload) begin
        valid_d = 1'b1;
        abort_d = skid_q.abort;
        pc_ff_d = skid_q.pc;
        instr_d = skid_q.data;
        state_d = skid_q.abort ? HALT : RUN;
        req_d   = ~skid_q.abort;
      end else if (state_q == RUN && !i_code_stall) begin
        valid_d = 1'b0;
      end
      // first request after reset
      if (state_q == RUN && !req_q && !i_code_stall) begin
        req_d  = 1'b1;
        addr_d = fetch_pc_q & ~32'd3;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_VECTOR;
      req_q      <= 1'b0;
      addr_q     <= '0;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      abort_q    <= 1'b0;
      pc_ff_q    <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      abort_q    <= abort_d;
      pc_ff_q    <= pc_ff_d;
      instr_q    <= instr_d;
    end
  end
  assign o_icache_req  = req_q;
  assign o_icache_addr = addr_q;
  assign o_valid       = valid_q;
  assign o_instr_abort = abort_q;
  assign o_pc_ff       = pc_ff_q;
  assign o_instruction = instr_q;
endmodule

// File: tb/tb_zap_fetch_sequencer.sv
// tb_zap_fetch_sequencer: directed scenarios against a cache model with an expected-PC scoreboard
module tb_zap_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, cwb, calu, cdec, thumb, ack, abt;
  logic [31:0] pwb, palu, pdec, data;
  logic        req, valid, iabort;
  logic [31:0] addr, pc_ff, instr;
  always #5 clk = ~clk;

  zap_fetch_sequencer #(.RESET_VECTOR(32'h100)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_code_stall           (stall),
    .i_clear_from_writeback (cwb),
    .i_pc_from_writeback    (pwb),
    .i_clear_from_alu       (calu),
    .i_pc_from_alu          (palu),
    .i_clear_from_decode    (cdec),
    .i_pc_from_decode       (pdec),
    .i_cpsr_ff_t            (thumb),
    .o_icache_req           (req),
    .o_icache_addr          (addr),
    .i_icache_ack           (ack),
    .i_icache_data          (data),
    .i_icache_abort         (abt),
    .o_pc_ff                (pc_ff),
    .o_instruction          (instr),
    .o_valid                (valid),
    .o_instr_abort          (iabort)
  );

  typedef struct {logic [31:0] pc; logic abort; bit b2b;} exp_t;
  exp_t        sb[$];
  int          vectors = 0, miscompares = 0, cyc = 0, last_cyc = -10;
  int          budget = 0, lat = 0, wcnt = 0;
  bit          busy = 0, prev_stall = 0, halted = 0;
  logic [31:0] cache_addr = '0, abort_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    if (!busy && req && budget > 0) begin
      busy = 1;
      cache_addr = addr;
      wcnt = 0;
    end
    ack  = busy && wcnt >= lat;
    data = ack ? mem(cache_addr) : 32'h0;
    abt  = ack && cache_addr == abort_addr;
    @(posedge clk);
    prev_stall = stall;
    cyc++;
    #1;
    if (ack) begin
      busy = 0;
      budget--;
    end else if (busy) wcnt++;
    if (valid && !prev_stall && !halted) begin
      chk("output_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_ff", pc_ff, e.pc);
        chk("instruction", instr, mem(e.pc & ~32'd3));
        chk("instr_abort", 32'(iabort), 32'(e.abort));
        if (e.b2b) chk("back_to_back_gap", 32'(cyc - last_cyc), 32'd1);
        last_cyc = cyc;
        if (e.abort) halted = 1;
      end
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() > 0; i++) step();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic redirect(input bit w, input bit a, input bit d,
                          input logic [31:0] tw, input logic [31:0] ta, input logic [31:0] td,
                          input logic [31:0] exp_addr);
    cwb = w; calu = a; cdec = d; pwb = tw; palu = ta; pdec = td;
    step();
    cwb = 0; calu = 0; cdec = 0;
    halted = 0;
    chk("clear_valid", 32'(valid), 32'd0);
    chk("clear_req", 32'(req), 32'd1);
    chk("clear_addr", addr, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1; stall = 0; cwb = 0; calu = 0; cdec = 0; thumb = 0;
    pwb = '0; palu = '0; pdec = '0; ack = 0; abt = 0; data = '0;
    step();
    step();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_abort", 32'(iabort), 32'd0);
    chk("rst_pc_ff", pc_ff, 32'd0);
    chk("rst_instr", instr, 32'd0);
    rst = 0;
    // ARM stream from the reset vector, stall on the ack for 0x108
    budget = 4; lat = 0;
    sb.push_back('{32'h100, 1'b0, 1'b0});
    sb.push_back('{32'h104, 1'b0, 1'b1});
    sb.push_back('{32'h108, 1'b0, 1'b0});
    sb.push_back('{32'h10C, 1'b0, 1'b1});
    for (int i = 0; i < 20 && !(req && addr == 32'h108); i++) step();
    chk("reach_108", addr, 32'h108);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", 32'(req), 32'd0);
      chk("stall_hold_pc", pc_ff, 32'h104);
      chk("stall_hold_valid", 32'(valid), 32'd1);
    end
    stall = 0;
    drain(20);
    // Thumb from 0x200; the ack landing with the clear is discarded
    thumb = 1; budget = 4;
    sb.push_back('{32'h200, 1'b0, 1'b0});
    sb.push_back('{32'h202, 1'b0, 1'b1});
    sb.push_back('{32'h204, 1'b0, 1'b1});
    redirect(1, 0, 0, 32'h200, 32'h0, 32'h0, 32'h200);
    drain(20);
    // ALU clear while a slow request is outstanding
    thumb = 0; lat = 2; budget = 2;
    sb.push_back('{32'h400, 1'b0, 1'b0});
    step();
    redirect(0, 1, 0, 32'h0, 32'h400, 32'h0, 32'h400);
    drain(20);
    // writeback beats decode in the same cycle
    lat = 0; budget = 2;
    sb.push_back('{32'h80, 1'b0, 1'b0});
    redirect(1, 0, 1, 32'h80, 32'h0, 32'h90, 32'h80);
    drain(20);
    // abort halts fetch until a decode clear
    abort_addr = 32'h10; budget = 2;
    sb.push_back('{32'h10, 1'b1, 1'b0});
    redirect(0, 0, 1, 32'h0, 32'h0, 32'h10, 32'h10);
    drain(20);
    chk("abort_valid", 32'(valid), 32'd1);
    chk("abort_flag", 32'(iabort), 32'd1);
    budget = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_req", 32'(req), 32'd0);
    end
    budget = 2;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    sb.push_back('{32'h4, 1'b0, 1'b1});
    redirect(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    drain(20);
    for (int i = 0; i < 5; i++) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
